// File: rtl/mc_pkg.sv
// mc_pkg: shared state encoding, opcode/func constants and datapath select codes for the multi-cycle MIPS control
package mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEMADR, S_MEM_RD,
        S_WB_MEM, S_MEM_WR, S_BRANCH, S_JAL, S_JR, S_HALT
    } state_t;

    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic jalr;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic ori;
        logic jal;
    } instr_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b001;

    localparam logic [1:0] PC_ALU = 2'b00;
    localparam logic [1:0] PC_OUT = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;
    localparam logic [1:0] PC_RS  = 2'b11;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MDR = 2'b01;
    localparam logic [1:0] MTR_LUI = 2'b10;
    localparam logic [1:0] MTR_PC  = 2'b11;

    localparam logic [1:0] ERR_ILL = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: maps IR op/func to a one-hot instruction class, flagging anything unsupported
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output instr_t     instr,
    output logic       illegal
);
    logic r_type;

    always_comb begin
        r_type     = (op == OP_RTYPE);
        instr      = '0;
        instr.addu = r_type && (func == FN_ADDU);
        instr.subu = r_type && (func == FN_SUBU);
        instr.jr   = r_type && (func == FN_JR);
        instr.jalr = r_type && (func == FN_JALR);
        instr.lw   = (op == OP_LW);
        instr.sw   = (op == OP_SW);
        instr.beq  = (op == OP_BEQ);
        instr.lui  = (op == OP_LUI);
        instr.ori  = (op == OP_ORI);
        instr.jal  = (op == OP_JAL);
        illegal    = ~|instr;
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM with memory valid/ack handshake, stall watchdog and retire counter
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 255,
    parameter bit ILLEGAL_HALT = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             i_or_d,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             ext_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_we,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic [1:0]       err
);
    localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [1:0]       err_q, err_d;
    instr_t           ins;
    logic             illegal;
    logic             req;

    mc_ctrl_decode u_decode (.op(op), .func(func), .instr(ins), .illegal(illegal));

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        wait_cnt_d = '0;
        req        = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        i_or_d     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_ctrl   = ALU_NOP;
        ext_op     = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = MTR_ALU;
        reg_we     = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            // state_q sits at S_FETCH during reset, so gating this state alone silences every output
            S_FETCH: begin
                req       = reset_n;
                mem_rd    = reset_n;
                alu_src_b = reset_n ? SRCB_4 : SRCB_B;
                alu_ctrl  = reset_n ? ALU_ADD : ALU_NOP;
                ir_we     = reset_n && mem_ack;
                pc_we     = reset_n && mem_ack;
                state_d   = mem_ack ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_BR;
                alu_ctrl   = ALU_ADD;
                state_d    = (ins.addu | ins.subu) ? S_EXEC_R :
                             (ins.jr | ins.jalr)   ? S_JR     :
                             (ins.lw | ins.sw)     ? S_MEMADR :
                             (ins.ori | ins.lui)   ? S_EXEC_I :
                             ins.beq               ? S_BRANCH :
                             ins.jal               ? S_JAL    :
                             ILLEGAL_HALT          ? S_HALT   : S_FETCH;
                err_d      = err_q | ((illegal && ILLEGAL_HALT) ? ERR_ILL : 2'b00);
                instr_done = illegal && !ILLEGAL_HALT;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ins.subu ? ALU_SUB : ALU_ADD;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_op    = 1'b1;
                alu_ctrl  = ALU_OR;
                state_d   = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                reg_dst    = (ins.addu | ins.subu) ? RD_RD : RD_RT;
                mem_to_reg = ins.lui ? MTR_LUI : MTR_ALU;
                state_d    = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = ALU_ADD;
                state_d   = ins.sw ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                req     = 1'b1;
                mem_rd  = 1'b1;
                i_or_d  = 1'b1;
                state_d = mem_ack ? S_WB_MEM : S_MEM_RD;
            end
            S_WB_MEM: begin
                mem_to_reg = MTR_MDR;
                reg_we     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                req        = 1'b1;
                mem_wr     = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ack;
                state_d    = mem_ack ? S_FETCH : S_MEM_WR;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = ALU_SUB;
                pc_src     = PC_OUT;
                pc_we      = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                reg_dst    = RD_RA;
                mem_to_reg = MTR_PC;
                reg_we     = 1'b1;
                pc_src     = PC_JMP;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JR: begin
                pc_src     = PC_RS;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                reg_dst    = ins.jalr ? RD_RD : RD_RT;
                mem_to_reg = ins.jalr ? MTR_PC : MTR_ALU;
                reg_we     = ins.jalr;
                state_d    = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // an ack arriving in the threshold cycle still completes the request
        if (req && !mem_ack) begin
            if (wait_cnt_q == WW'(MEM_WAIT_MAX - 1)) begin
                state_d = S_HALT;
                err_d   = err_d | ERR_TMO;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
        retired_d = retired_q + CNT_W'(instr_done);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            retired_q  <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
            err_q      <= err_d;
        end
    end

    assign retired = retired_q;
    assign err     = err_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized instruction streams against a latency/strobe-count model of the control sequence
module tb_mc_ctrl_fsm;
    logic       clk = 1'b0, reset_n = 1'b0, zero = 1'b0, mem_ack = 1'b0;
    logic [5:0] op = '0, func = '0;
    logic       mem_rd, mem_wr, i_or_d, ir_we, pc_we, alu_src_a, ext_op, reg_we, instr_done;
    logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg, err;
    logic [2:0] alu_ctrl;
    logic [3:0] retired;
    int errors = 0, checks = 0, exp_ret = 0;

    // kinds: 0 addu 1 subu 2 jr 3 jalr 4 lw 5 sw 6 beq 7 lui 8 ori 9 jal
    localparam logic [5:0] OPS [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h0f, 6'h0d, 6'h03};
    localparam logic [5:0] FNS [4]  = '{6'h21, 6'h23, 6'h08, 6'h09};
    localparam int BASE [10] = '{4, 4, 3, 3, 5, 4, 3, 4, 4, 3};
    localparam int RW   [10] = '{1, 1, 0, 1, 1, 0, 0, 1, 1, 1};
    localparam int RD   [10] = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 2};
    localparam int MTR  [10] = '{0, 0, 0, 3, 1, 0, 0, 2, 0, 3};
    localparam int PCS  [10] = '{0, 0, 3, 3, 0, 0, 1, 0, 0, 2};
    localparam int JMP  [10] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 1};
    localparam int ALU  [10] = '{2, 3, 0, 0, 2, 2, 3, 1, 1, 0};

    mc_ctrl_fsm #(.MEM_WAIT_MAX(4), .ILLEGAL_HALT(1'b1), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .func(func), .zero(zero), .mem_ack(mem_ack),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .i_or_d(i_or_d), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .ext_op(ext_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_we(reg_we),
        .instr_done(instr_done), .retired(retired), .err(err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset_n = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_ret = 0;
    endtask

    // fw/mw: stall cycles before ack on the fetch and data requests
    task automatic do_instr(input int k, input int fw, input int mw, input logic z);
        int n = 0, nreq = 0, wc = 0, rd_c = 0, wr_c = 0, pcwe_c = 0, rwe_c = 0, irwe_c = 0, iod_bad = 0;
        int exp_n, exp_rd, exp_wr, exp_pcwe;
        logic [2:0] alu_x = 3'b111;
        logic [1:0] srcb_d = 2'b00, l_pcsrc = 2'b00, l_rd = 2'b00, l_mtr = 2'b00;
        logic l_pcwe = 1'b0, l_rwe = 1'b0, fin = 1'b0;
        op = OPS[k];
        func = (k < 4) ? FNS[k] : 6'($urandom);
        zero = z;
        while (!fin && n < 40) begin
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            if (mem_rd || mem_wr) mem_ack = (wc == ((nreq == 0) ? fw : mw));
            #1;
            if ((mem_rd || mem_wr) && i_or_d !== (nreq > 0)) iod_bad++;
            if (mem_rd || mem_wr) begin
                if (mem_ack) begin
                    nreq++;
                    wc = 0;
                end else wc++;
            end
            rd_c += int'(mem_rd);
            wr_c += int'(mem_wr);
            pcwe_c += int'(pc_we);
            rwe_c += int'(reg_we);
            irwe_c += int'(ir_we);
            if (n == fw + 1) srcb_d = alu_src_b;
            if (n == fw + 2) alu_x = alu_ctrl;
            if (instr_done) begin
                fin = 1'b1;
                l_pcwe = pc_we;
                l_pcsrc = pc_src;
                l_rwe = reg_we;
                l_rd = reg_dst;
                l_mtr = mem_to_reg;
            end
            n++;
        end
        #4 mem_ack = 1'b0;
        exp_n = BASE[k] + fw + ((k == 4 || k == 5) ? mw : 0);
        exp_rd = 1 + fw + ((k == 4) ? 1 + mw : 0);
        exp_wr = (k == 5) ? 1 + mw : 0;
        exp_pcwe = (k == 6) ? int'(z) : JMP[k];
        if (fin) exp_ret = (exp_ret + 1) % 16;
        checks++;
        if (!fin) begin errors++; $display("FAIL kind %0d done: no instr_done within 40 cycles", k); end
        checks++;
        if (n !== exp_n) begin errors++; $display("FAIL kind %0d latency: got %0d expected %0d", k, n, exp_n); end
        checks++;
        if (rd_c !== exp_rd || wr_c !== exp_wr) begin
            errors++; $display("FAIL kind %0d mem cycles: rd %0d wr %0d expected rd %0d wr %0d", k, rd_c, wr_c, exp_rd, exp_wr);
        end
        checks++;
        if (iod_bad !== 0 || irwe_c !== 1) begin
            errors++; $display("FAIL kind %0d i_or_d/ir_we: bad %0d ir_we %0d expected 0 and 1", k, iod_bad, irwe_c);
        end
        checks++;
        if (pcwe_c !== 1 + exp_pcwe || int'(l_pcwe) !== exp_pcwe) begin
            errors++; $display("FAIL kind %0d pc_we: count %0d last %0d expected %0d last %0d", k, pcwe_c, l_pcwe, 1 + exp_pcwe, exp_pcwe);
        end
        checks++;
        if (rwe_c !== RW[k] || int'(l_rwe) !== RW[k] || int'(l_rd) !== RD[k] || int'(l_mtr) !== MTR[k]) begin
            errors++; $display("FAIL kind %0d writeback: reg_we %0d/%0d reg_dst %0d mem_to_reg %0d expected %0d %0d %0d",
                               k, rwe_c, l_rwe, l_rd, l_mtr, RW[k], RD[k], MTR[k]);
        end
        checks++;
        if (int'(l_pcsrc) !== PCS[k]) begin errors++; $display("FAIL kind %0d pc_src: got %0d expected %0d", k, l_pcsrc, PCS[k]); end
        checks++;
        if (int'(alu_x) !== ALU[k] || srcb_d !== 2'b11) begin
            errors++; $display("FAIL kind %0d alu: exec ctrl %0d decode srcb %0d expected %0d and 3", k, alu_x, srcb_d, ALU[k]);
        end
        checks++;
        if (retired !== 4'(exp_ret) || err !== 2'b00) begin
            errors++; $display("FAIL kind %0d retired/err: got %0d/%0d expected %0d/0", k, retired, err, exp_ret);
        end
    endtask

    task automatic test_reset();
        mem_ack = 1'b1;
        op = OPS[2];
        func = FNS[2];
        @(negedge clk);
        #1;
        checks++;
        if ({mem_rd, mem_wr, ir_we, pc_we, reg_we, instr_done} !== 6'b0 || alu_src_b !== 2'b00 || alu_ctrl !== 3'b000) begin
            errors++; $display("FAIL reset outputs: enables %b srcb %0d alu %0d expected all 0",
                               {mem_rd, mem_wr, ir_we, pc_we, reg_we, instr_done}, alu_src_b, alu_ctrl);
        end
        checks++;
        if (retired !== 4'd0 || err !== 2'b00) begin errors++; $display("FAIL reset state: retired %0d err %0d expected 0 0", retired, err); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (!(ir_we === 1'b1 && pc_we === 1'b1 && mem_rd === 1'b1)) begin
            errors++; $display("FAIL first fetch: ir_we %b pc_we %b mem_rd %b expected 1 1 1", ir_we, pc_we, mem_rd);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if (alu_src_b !== 2'b11 || ir_we !== 1'b0) begin errors++; $display("FAIL decode after reset: srcb %0d ir_we %b expected 3 0", alu_src_b, ir_we); end
        @(negedge clk);
        #1;
        checks++;
        if (instr_done !== 1'b1 || pc_src !== 2'b11) begin errors++; $display("FAIL jr after reset: done %b pc_src %0d expected 1 3", instr_done, pc_src); end
        #6;
        checks++;
        if (retired !== 4'd1) begin errors++; $display("FAIL retired after first: got %0d expected 1", retired); end
        do_reset();
    endtask

    task automatic test_addu();       do_instr(0, 0, 0, 1'b0); endtask
    task automatic test_lw_wait();    do_instr(4, 0, 3, 1'b0); endtask
    task automatic test_beq();        do_instr(6, 0, 0, 1'b0); do_instr(6, 0, 0, 1'b1); endtask
    task automatic test_jal_jalr();   do_instr(9, 0, 0, 1'b0); do_instr(3, 0, 0, 1'b0); endtask
    task automatic test_ack_threshold(); do_reset(); do_instr(8, 3, 0, 1'b0); do_instr(5, 0, 3, 1'b0); endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++)
            do_instr(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_illegal();
        int act = 0;
        do_reset();
        op = 6'h3f;
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ack = 1'b1;
            #2;
            act += int'(mem_rd | mem_wr | ir_we | pc_we | reg_we | instr_done);
        end
        checks++;
        if (err !== 2'b01) begin errors++; $display("FAIL illegal err: got %b expected 01", err); end
        checks++;
        if (act !== 0 || retired !== 4'd0) begin errors++; $display("FAIL illegal halt: active cycles %0d retired %0d expected 0 0", act, retired); end
        do_reset();
    endtask

    task automatic test_timeout();
        int rd_n = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            rd_n += int'(mem_rd);
        end
        @(negedge clk);
        #2;
        checks++;
        if (rd_n !== 4 || mem_rd !== 1'b0 || err !== 2'b10) begin
            errors++; $display("FAIL timeout: fetch cycles %0d mem_rd %b err %b expected 4 0 10", rd_n, mem_rd, err);
        end
    endtask

    task automatic test_reset_mid_write();
        bit seen = 1'b0;
        do_reset();
        op = OPS[5];
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            if (mem_wr) seen = 1'b1;
            else mem_ack = mem_rd;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (!seen || mem_wr !== 1'b0 || i_or_d !== 1'b0 || instr_done !== 1'b0 || retired !== 4'd0) begin
            errors++; $display("FAIL reset mid write: reached %0d mem_wr %b i_or_d %b done %b retired %0d expected 1 0 0 0 0",
                               seen, mem_wr, i_or_d, instr_done, retired);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw_wait();
        test_beq();
        test_jal_jalr();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_ack_threshold();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
